// File: rtl/bcd_mod_counter.sv
// Parametrised packed-BCD modulo counter with up/down stepping, range-checked load,
// combinational terminal count for cascading, and registered wrap / load-error pulses.
module bcd_mod_counter #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 24,
  parameter int MIN_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   out,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W       = 4 * DIGITS;
  localparam int MAX_VAL = MIN_VAL + MODULUS - 1;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] b;
    int           r;
    b = '0;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r           = r / 10;
    end
    return b;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Digit-wise a <= b, scanning from the most significant digit down.
  function automatic logic bcd_le(input logic [W-1:0] a, input logic [W-1:0] b);
    logic res;
    logic decided;
    res     = 1'b1;
    decided = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        res     = (a[4*i +: 4] < b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic         at_max;
  logic         at_min;
  logic         load_ok;
  logic [W-1:0] out_nxt;
  logic         wrap_nxt;
  logic         err_nxt;

  assign at_max  = (out == MAX_BCD);
  assign at_min  = (out == MIN_BCD);
  assign load_ok = is_bcd(load_val) && bcd_le(MIN_BCD, load_val) && bcd_le(load_val, MAX_BCD);
  assign tc      = en & (up ? at_max : at_min);

  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if (load_ok) out_nxt = load_val;
      else         err_nxt = 1'b1;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          out_nxt  = MIN_BCD;
          wrap_nxt = 1'b1;
        end else begin
          out_nxt = bcd_inc(out);
        end
      end else begin
        if (at_min) begin
          out_nxt  = MAX_BCD;
          wrap_nxt = 1'b1;
        end else begin
          out_nxt = bcd_dec(out);
        end
      end
    end
  end

  // Single register stage: count value and its event pulses update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out      <= MIN_BCD;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      out      <= out_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench: 24-hour, 12-hour and a cascaded 60x24 pair of bcd_mod_counter
// checked against an integer reference model.
module tb_bcd_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, en_c, ld_c;
  logic [7:0] load_val, lv_lo, lv_hi;
  logic [7:0] out24, out12, out_lo, out_hi;
  logic       tc24, tc12, tc_lo, tc_hi;
  logic       wr24, wr12, wr_lo, wr_hi;
  logic       le24, le12, le_lo, le_hi;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .MIN_VAL(0)) u24 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out24), .tc(tc24), .wrap(wr24), .load_err(le24));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(12), .MIN_VAL(1)) u12 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .out(out12), .tc(tc12), .wrap(wr12), .load_err(le12));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .MIN_VAL(0)) u_lo (
    .clk(clk), .rst(rst), .en(en_c), .up(up), .load(ld_c), .load_val(lv_lo),
    .out(out_lo), .tc(tc_lo), .wrap(wr_lo), .load_err(le_lo));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .MIN_VAL(0)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up(up), .load(ld_c), .load_val(lv_hi),
    .out(out_hi), .tc(tc_hi), .wrap(wr_hi), .load_err(le_hi));

  typedef struct packed {
    logic [3:0][7:0] o;
    logic [3:0]      w;
    logic [3:0]      e;
    logic [3:0]      t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int MN [4] = '{0, 1, 0, 0};
  localparam int MX [4] = '{23, 12, 59, 23};
  int m  [4];
  bit mw [4];
  bit me [4];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  // Reference step for one counter on integers: load (range-checked) > enable > hold.
  task automatic adv(input int i, input bit e, input bit u, input bit l, input logic [7:0] lv);
    int v;
    bit ok;
    mw[i] = 1'b0;
    me[i] = 1'b0;
    if (l) begin
      ok = (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9);
      v  = int'(lv[7:4]) * 10 + int'(lv[3:0]);
      ok = ok && (v >= MN[i]) && (v <= MX[i]);
      if (ok) m[i] = v;
      else    me[i] = 1'b1;
    end else if (e) begin
      if (u) begin
        if (m[i] == MX[i]) begin m[i] = MN[i]; mw[i] = 1'b1; end
        else m[i] = m[i] + 1;
      end else begin
        if (m[i] == MN[i]) begin m[i] = MX[i]; mw[i] = 1'b1; end
        else m[i] = m[i] - 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit u,
                     input bit l = 1'b0, input logic [7:0] lv = 8'h00,
                     input bit ec = 1'b0, input bit lc = 1'b0,
                     input logic [7:0] llo = 8'h00, input logic [7:0] lhi = 8'h00);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; up = u; load = l; load_val = lv;
    en_c = ec; ld_c = lc; lv_lo = llo; lv_hi = lhi;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m[i] = MN[i]; mw[i] = 1'b0; me[i] = 1'b0;
      end
    end
    x.t[0] = e  && (u ? (m[0] == MX[0]) : (m[0] == MN[0]));
    x.t[1] = e  && (u ? (m[1] == MX[1]) : (m[1] == MN[1]));
    x.t[2] = ec && (u ? (m[2] == MX[2]) : (m[2] == MN[2]));
    x.t[3] = x.t[2] && (u ? (m[3] == MX[3]) : (m[3] == MN[3]));
    for (int i = 0; i < 4; i++) begin
      x.o[i] = to_bcd(m[i]);
      x.w[i] = mw[i];
      x.e[i] = me[i];
    end
    q.push_back(x);
    if (r) begin
      adv(0, e, u, l, lv);
      adv(1, e, u, l, lv);
      adv(2, ec, u, lc, llo);
      adv(3, x.t[2], u, lc, lhi);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("out24", out24, x.o[0]);  chk("wrap24", 8'(wr24), 8'(x.w[0]));
      chk("err24", 8'(le24), 8'(x.e[0])); chk("tc24", 8'(tc24), 8'(x.t[0]));
      chk("out12", out12, x.o[1]);  chk("wrap12", 8'(wr12), 8'(x.w[1]));
      chk("err12", 8'(le12), 8'(x.e[1])); chk("tc12", 8'(tc12), 8'(x.t[1]));
      chk("out_lo", out_lo, x.o[2]); chk("wrap_lo", 8'(wr_lo), 8'(x.w[2]));
      chk("err_lo", 8'(le_lo), 8'(x.e[2])); chk("tc_lo", 8'(tc_lo), 8'(x.t[2]));
      chk("out_hi", out_hi, x.o[3]); chk("wrap_hi", 8'(wr_hi), 8'(x.w[3]));
      chk("err_hi", 8'(le_hi), 8'(x.e[3])); chk("tc_hi", 8'(tc_hi), 8'(x.t[3]));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    en_c = 1'b0; ld_c = 1'b0; lv_lo = 8'h00; lv_hi = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m[i] = MN[i]; mw[i] = 1'b0; me[i] = 1'b0;
    end

    repeat (3) cyc(0, 1, 1);
    cyc(1, 0, 1);
    repeat (15) cyc(1, 1, 1);
    cyc(0, 0, 1);
    cyc(1, 0, 1);
    repeat (26) cyc(1, 1, 1);

    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (5) cyc(1, 1, 0);

    cyc(1, 0, 1, 1, 8'h17);
    cyc(1, 0, 1, 1, 8'h24);
    cyc(1, 0, 1, 1, 8'h1A);
    cyc(1, 0, 1);
    cyc(1, 1, 1, 1, 8'h05);
    cyc(1, 1, 0, 1, 8'h11);
    cyc(1, 0, 1);

    cyc(1, 0, 1, 0, 8'h00, 0, 1, 8'h59, 8'h23);
    cyc(1, 0, 1, 0, 8'h00, 1);
    cyc(1, 0, 1, 0, 8'h00, 1);
    cyc(1, 0, 0, 0, 8'h00, 1);
    cyc(1, 0, 0, 0, 8'h00, 1);
    cyc(1, 0, 1, 0, 8'h00, 0);
    cyc(1, 0, 1, 0, 8'h00, 0, 1, 8'h60, 8'h05);
    cyc(1, 0, 1);

    for (int n = 0; n < 300; n++) begin
      logic [7:0] lv;
      if ($urandom_range(0, 1) == 0) lv = to_bcd(int'($urandom_range(0, 29)));
      else                           lv = 8'($urandom);
      cyc($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 7) == 0, lv,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          to_bcd(int'($urandom_range(0, 65))), to_bcd(int'($urandom_range(0, 27))));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
